bsg_arb_pkt_lock_rr: RTL and testbench

//  Round-robin arbiter that shares one downstream valid/ready channel among

---
 rtl/bsg_arb_pkt_lock_pkg.sv | 16 +
 rtl/bsg_rr_pick.sv | 37 +++
 rtl/bsg_arb_pkt_lock_rr.sv | 156 +++++++++++++++
 tb/tb_bsg_arb_pkt_lock_rr.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_arb_pkt_lock_pkg.sv
// Shared types for the packet-locking round-robin arbiter.
//   state_e : arbiter state, idle (arbitrating every cycle) or locked
//             (grant held by one source until its packet completes).
package bsg_arb_pkt_lock_pkg;

  typedef enum logic {
    eIdle   = 1'b0,
    eLocked = 1'b1
  } state_e;

  // Index width for a given source count; a single source still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_rr_pick.sv
// Combinational rotate-priority picker.
// Scans requests starting just after the last winner and wrapping around,
// returning the first requester found.
// Ports:
//   v_i            in  [inputs_p]      request vector
//   last_i         in  [idx_width_p]   index of the previous winner
//   pick_one_hot_o out [inputs_p]      one-hot winner, zero when no request
//   pick_idx_o     out [idx_width_p]   winner index (0 when no request)
module bsg_rr_pick #(
  parameter int inputs_p    = 4,
  parameter int idx_width_p = 2
) (
  input  logic [inputs_p-1:0]    v_i,
  input  logic [idx_width_p-1:0] last_i,
  output logic [inputs_p-1:0]    pick_one_hot_o,
  output logic [idx_width_p-1:0] pick_idx_o
);

  always_comb begin
    int  cand;
    logic found;
    pick_one_hot_o = '0;
    pick_idx_o     = '0;
    found          = 1'b0;
    cand           = 0;
    // Offsets 1..inputs_p visit last+1 first and last itself at the very end.
    for (int off = 1; off <= inputs_p; off++) begin
      cand = (int'(last_i) + off) % inputs_p;
      if (!found && v_i[cand]) begin
        found                = 1'b1;
        pick_one_hot_o[cand] = 1'b1;
        pick_idx_o           = idx_width_p'(cand);
      end
    end
  end

endmodule

// File: rtl/bsg_arb_pkt_lock_rr.sv
// Round-robin arbiter sharing one valid/ready channel among inputs_p packet
// sources. The header beat carries the packet length (beats-1); once a
// multi-beat packet is granted the grant is held until its last beat is
// accepted, and rotation only advances at packet end.
// Ports:
//   clk_i          in   clock
//   reset_i        in   asynchronous active-high reset
//   v_i            in   [inputs_p]             per-source beat valid
//   len_i          in   [inputs_p*len_width_p] per-source header length (beats-1)
//   yumi_o         out  [inputs_p]             one-hot, beat consumed this cycle
//   ready_i        in   downstream can accept a beat
//   v_o            out  downstream beat valid
//   sel_one_hot_o  out  [inputs_p]             data-mux select, one-hot or zero
//   locked_o       out  grant held mid-packet
module bsg_arb_pkt_lock_rr
  import bsg_arb_pkt_lock_pkg::*;
#(
  parameter int inputs_p    = 4,
  parameter int len_width_p = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [inputs_p-1:0]             v_i,
  input  logic [inputs_p*len_width_p-1:0] len_i,
  output logic [inputs_p-1:0]             yumi_o,
  input  logic                            ready_i,
  output logic                            v_o,
  output logic [inputs_p-1:0]             sel_one_hot_o,
  output logic                            locked_o
);

  localparam int idx_w_lp = idx_width(inputs_p);
  localparam logic [len_width_p-1:0] one_lp  = len_width_p'(1);
  localparam logic [idx_w_lp-1:0]    last_rst_lp = idx_w_lp'(inputs_p - 1);

  state_e                 state_r, state_n;
  logic [idx_w_lp-1:0]    owner_r, owner_n;
  logic [idx_w_lp-1:0]    last_r, last_n;
  logic [len_width_p-1:0] cnt_r, cnt_n;

  logic [inputs_p-1:0]    pick_oh;
  logic [idx_w_lp-1:0]    pick_idx;
  logic [len_width_p-1:0] len_a [inputs_p];
  logic [len_width_p-1:0] pick_len;
  logic [inputs_p-1:0]    owner_oh;
  logic                   hs;
  logic                   last_beat;

  for (genvar k = 0; k < inputs_p; k++) begin : g_len
    assign len_a[k] = len_i[k*len_width_p +: len_width_p];
  end

  bsg_rr_pick #(
    .inputs_p    (inputs_p),
    .idx_width_p (idx_w_lp)
  ) u_pick (
    .v_i            (v_i),
    .last_i         (last_r),
    .pick_one_hot_o (pick_oh),
    .pick_idx_o     (pick_idx)
  );

  assign pick_len = len_a[pick_idx];

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_r] = 1'b1;
  end

  // ---- state register ----
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= eIdle;
      owner_r <= '0;
      last_r  <= last_rst_lp;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      owner_r <= owner_n;
      last_r  <= last_n;
      cnt_r   <= cnt_n;
    end
  end

  // ---- grant outputs and next state ----
  always_comb begin
    sel_one_hot_o = '0;
    v_o           = 1'b0;
    yumi_o        = '0;
    locked_o      = 1'b0;
    hs            = 1'b0;
    last_beat     = 1'b0;
    state_n       = state_r;
    owner_n       = owner_r;
    last_n        = last_r;
    cnt_n         = cnt_r;
    case (state_r)
      eIdle: begin
        sel_one_hot_o = pick_oh;
        v_o           = |v_i;
        yumi_o        = pick_oh & {inputs_p{ready_i}};
        hs            = v_o & ready_i;
        if (hs) begin
          if (pick_len == '0) begin
            last_n = pick_idx;
          end else begin
            state_n = eLocked;
            owner_n = pick_idx;
            cnt_n   = pick_len;
          end
        end
      end
      eLocked: begin
        // Owner bubbles keep the lock; no other source may slip in.
        locked_o      = 1'b1;
        sel_one_hot_o = owner_oh;
        v_o           = v_i[owner_r];
        yumi_o        = owner_oh & {inputs_p{v_i[owner_r] & ready_i}};
        hs            = v_o & ready_i;
        last_beat     = hs && (cnt_r == one_lp);
        if (hs) begin
          cnt_n = cnt_r - one_lp;
          if (last_beat) begin
            state_n = eIdle;
            last_n  = owner_r;
          end
        end
      end
      default: begin
        state_n = eIdle;
      end
    endcase
  end

`ifndef SYNTHESIS
  logic                hold_chk_r;
  logic [inputs_p-1:0] sel_prev_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hold_chk_r <= 1'b0;
      sel_prev_r <= '0;
    end else begin
      a_yumi_onehot: assert ($onehot0(yumi_o));
      a_sel_onehot:  assert ($onehot0(sel_one_hot_o));
      a_yumi_valid:  assert ((yumi_o & ~v_i) == '0);
      if (hold_chk_r) begin
        a_lock_hold: assert (locked_o && (sel_one_hot_o == sel_prev_r));
      end
      hold_chk_r <= locked_o && !last_beat;
      sel_prev_r <= sel_one_hot_o;
    end
  end
`endif

endmodule

// File: tb/tb_bsg_arb_pkt_lock_rr.sv
module tb_bsg_arb_pkt_lock_rr;

  localparam int N  = 4;
  localparam int LW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      v;
  logic [N*LW-1:0]   len;
  logic              ready;
  logic [N-1:0]      yumi;
  logic              v_out;
  logic [N-1:0]      sel;
  logic              locked;

  int checks   = 0;
  int failures = 0;

  // Reference model: packet bookkeeping in beats, not a state-machine copy.
  bit m_busy;
  int m_owner;
  int m_last;
  int m_done;
  int m_total;

  always #5 clk = ~clk;

  bsg_arb_pkt_lock_rr #(.inputs_p(N), .len_width_p(LW)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .v_i           (v),
    .len_i         (len),
    .yumi_o        (yumi),
    .ready_i       (ready),
    .v_o           (v_out),
    .sel_one_hot_o (sel),
    .locked_o      (locked)
  );

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = N - 1;
    m_done  = 0;
    m_total = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_len(input int k, input int val);
    len[k*LW +: LW] = LW'(val);
  endtask

  // One clock: compare all outputs against the model, then advance the model.
  task automatic cycle(input string tag, output logic [N-1:0] yumi_seen, output logic locked_seen);
    int           pick;
    int           ln;
    logic [N-1:0] es;
    logic [N-1:0] ey;
    logic         ev;
    logic         el;
    @(negedge clk);
    pick = -1;
    es   = '0;
    if (!m_busy) begin
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (m_last + i) % N;
        if (pick < 0 && v[c]) pick = c;
      end
      if (pick >= 0) es[pick] = 1'b1;
      ev = |v;
      el = 1'b0;
    end else begin
      es[m_owner] = 1'b1;
      ev = v[m_owner];
      el = 1'b1;
    end
    ey = (ev && ready) ? es : '0;
    chk({tag, ".yumi"},   32'(yumi),   32'(ey));
    chk({tag, ".v_o"},    32'(v_out),  32'(ev));
    chk({tag, ".sel"},    32'(sel),    32'(es));
    chk({tag, ".locked"}, 32'(locked), 32'(el));
    yumi_seen   = yumi;
    locked_seen = locked;
    @(posedge clk);
    if (ev && ready) begin
      if (!m_busy) begin
        ln = int'(len[pick*LW +: LW]);
        if (ln == 0) begin
          m_last = pick;
        end else begin
          m_busy  = 1'b1;
          m_owner = pick;
          m_total = ln + 1;
          m_done  = 1;
        end
      end else begin
        m_done++;
        if (m_done == m_total) begin
          m_busy = 1'b0;
          m_last = m_owner;
        end
      end
    end
    #1;
  endtask

  initial begin
    logic [N-1:0] y;
    logic         lk;
    logic [N-1:0] exp1 [5];
    logic [N-1:0] exp2y [4];
    logic         exp2l [4];
    int           pulses;

    reset = 1'b1;
    v     = '0;
    len   = '0;
    ready = 1'b0;
    model_reset();

    // Reset state
    #12;
    chk("rst.yumi",   32'(yumi),   32'd0);
    chk("rst.v_o",    32'(v_out),  32'd0);
    chk("rst.sel",    32'(sel),    32'd0);
    chk("rst.locked", 32'(locked), 32'd0);
    #5;
    reset = 1'b0;

    // Test 1: single-beat packets rotate through all sources
    exp1[0] = 4'b0001; exp1[1] = 4'b0010; exp1[2] = 4'b0100;
    exp1[3] = 4'b1000; exp1[4] = 4'b0001;
    v     = 4'b1111;
    ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle("t1", y, lk);
      chk("t1.seq", 32'(y), 32'(exp1[k]));
      chk("t1.unlocked", 32'(lk), 32'd0);
    end

    // Test 2: three-beat packet from source 1 holds the grant
    exp2y[0] = 4'b0010; exp2y[1] = 4'b0010; exp2y[2] = 4'b0010; exp2y[3] = 4'b0100;
    exp2l[0] = 1'b0;    exp2l[1] = 1'b1;    exp2l[2] = 1'b1;    exp2l[3] = 1'b0;
    v = 4'b0110;
    set_len(1, 2);
    for (int k = 0; k < 4; k++) begin
      cycle("t2", y, lk);
      chk("t2.seq", 32'(y), 32'(exp2y[k]));
      chk("t2.lock", 32'(lk), 32'(exp2l[k]));
    end

    // Test 3: owner bubbles keep the lock
    set_len(1, 3);
    v = 4'b0110;
    cycle("t3", y, lk);
    cycle("t3", y, lk);
    v = 4'b0100;
    for (int k = 0; k < 2; k++) begin
      cycle("t3.bubble", y, lk);
      chk("t3.bubble_yumi", 32'(y), 32'd0);
      chk("t3.bubble_lock", 32'(lk), 32'd1);
    end
    v = 4'b0110;
    for (int k = 0; k < 2; k++) begin
      cycle("t3.resume", y, lk);
      chk("t3.resume_yumi", 32'(y), 32'b0010);
    end
    cycle("t3.next", y, lk);
    chk("t3.next_grant", 32'(y), 32'b0100);

    // Test 4: backpressure mid-packet preserves the beat count
    v = 4'b0001;
    set_len(0, 4);
    cycle("t4", y, lk);
    cycle("t4", y, lk);
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle("t4.stall", y, lk);
      chk("t4.stall_yumi", 32'(y), 32'd0);
    end
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle("t4.drain", y, lk);
      chk("t4.drain_yumi", 32'(y), 32'b0001);
    end
    v = 4'b0000;
    cycle("t4.closed", y, lk);
    chk("t4.closed_lock", 32'(lk), 32'd0);

    // Test 5: maximum length packet
    set_len(3, 15);
    set_len(0, 0);
    v      = 4'b1000;
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      cycle("t5", y, lk);
      if (y[3]) pulses++;
    end
    chk("t5.pulses", 32'(pulses), 32'd16);
    v = 4'b1001;
    cycle("t5.next", y, lk);
    chk("t5.next_grant", 32'(y), 32'b0001);

    // Test 6: asynchronous reset mid-packet
    v = 4'b0010;
    set_len(1, 3);
    cycle("t6", y, lk);
    cycle("t6", y, lk);
    chk("t6.pre_lock", 32'(locked), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6.async_drop", 32'(locked), 32'd0);
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    v = 4'b1010;
    cycle("t6.after", y, lk);
    chk("t6.first_grant", 32'(y), 32'b0010);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      v     = N'($urandom);
      len   = (N*LW)'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
      end
      cycle("rnd", y, lk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
